// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the pipeline M-stage
// (CPU) and an external requester (EXT: loader or debug DMA). One RAM access
// is made per cycle. The CPU wins by default. Two mechanisms guarantee EXT
// forward progress:
//   - a starvation counter, which forces an EXT grant after MAX_WAIT refusals;
//   - a lock bit, which lets EXT keep the RAM for a bounded burst.
// stall_M tells the pipeline to hold whenever EXT owns the RAM.
//
// Optional feature macro: DMEM_ARB_STATS_EN adds the conflict_cnt and
// ext_grant_cnt statistics outputs. When it is undefined those ports do not
// exist.
//
// Handshake: ext_req is held high until ext_gnt. ext_gnt=1 means the EXT
// access is performed at the coming clock edge. For a read, ext_rvalid and
// ext_rdata follow one cycle later. The CPU side has no handshake: stall_M=1
// means the CPU access was not performed this cycle.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_M,
  input  logic              memWrite_M,
  input  logic [ADDR_W-1:0] ALU_out_M,
  input  logic [DATA_W-1:0] writeData_M,
  output logic [DATA_W-1:0] read_data_M,
  output logic              stall_M,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd,
  output logic              o_dbg_state
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       ext_grant_cnt
`endif
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  typedef enum logic {
    CPU_OWN   = 1'b0,
    EXT_BURST = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] w_burst_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               w_cpu_req;
  logic               w_owner_ext;

  assign w_cpu_req   = memRead_M | memWrite_M;
  assign o_dbg_state = r_state;

  // While reset is low, the owner is forced to the CPU.
  // Otherwise EXT owns the RAM when it requests and any of these holds:
  //   - the CPU is idle;
  //   - EXT has been starved for MAX_WAIT cycles;
  //   - EXT is inside a locked burst.
  assign w_owner_ext = reset && ext_req &&
                       (!w_cpu_req || (r_wait_cnt == WAIT_MAX) || (r_state == EXT_BURST));

  // State register: FSM state and the burst grant counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CPU_OWN;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Next-state logic.
  // burst_cnt counts the locked grants in the current burst. The FSM leaves
  // EXT_BURST on the edge where that count reaches MAX_BURST, so a burst never
  // exceeds MAX_BURST consecutive grants. The following cycle goes to the CPU
  // if it is requesting.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      CPU_OWN: begin
        if (w_owner_ext && ext_lock) begin
          w_burst_nxt = BURST_ONE;
          w_state_nxt = (BURST_ONE == BURST_MAX) ? CPU_OWN : EXT_BURST;
        end
      end
      EXT_BURST: begin
        if (w_owner_ext && ext_lock && (r_burst_cnt < BURST_MAX)) begin
          w_burst_nxt = r_burst_cnt + BURST_ONE;
          w_state_nxt = ((r_burst_cnt + BURST_ONE) == BURST_MAX) ? CPU_OWN : EXT_BURST;
        end else begin
          w_state_nxt = CPU_OWN;
        end
      end
      default: w_state_nxt = CPU_OWN;
    endcase
  end

  // Output logic: grant, stall and the RAM port mux, all driven by the owner.
  always_comb begin
    ext_gnt     = w_owner_ext;
    stall_M     = w_cpu_req && w_owner_ext;
    ram_a       = w_owner_ext ? ext_addr  : ALU_out_M;
    ram_wd      = w_owner_ext ? ext_wdata : writeData_M;
    ram_we      = reset && (w_owner_ext ? ext_we : (memWrite_M && !stall_M));
    read_data_M = ram_rd;
  end

  // Starvation counter.
  // It counts refused EXT cycles and saturates at MAX_WAIT. It is cleared
  // when EXT is granted or stops requesting, so a forced release restarts it
  // at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (ext_req && !w_owner_ext) begin
      if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // EXT read return path: the data is captured one cycle after a read grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= w_owner_ext && !ext_we;
      if (w_owner_ext && !ext_we) ext_rdata <= ram_rd;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating statistics: cycles with a CPU stall, and EXT grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt  <= '0;
      ext_grant_cnt <= '0;
    end else begin
      if (stall_M && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
      if (ext_gnt && (ext_grant_cnt != 16'hFFFF)) ext_grant_cnt <= ext_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for dmem_arbiter, with a small RAM model.
// The driver applies one cycle of inputs at a time and pushes the
// hand-computed expected outputs for that cycle onto exp_q. The monitor pops
// one entry on each falling edge and compares it with the DUT outputs.
module tb_dmem_arbiter;

  localparam int EW = 102;

  logic        clk;
  logic        rst_n;
  logic        memRead_M, memWrite_M;
  logic [31:0] ALU_out_M, writeData_M, read_data_M;
  logic        stall_M;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic        ram_we;
  logic        dbg_state;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, ext_grant_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  int          n_vec;
  int          n_err;
  logic [31:0] exp_rdata;
  logic [15:0] exp_conf, exp_gcnt;
  logic [31:0] mem [0:255];

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(rst_n),
    .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .ALU_out_M(ALU_out_M), .writeData_M(writeData_M),
    .read_data_M(read_data_M), .stall_M(stall_M),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_a(ram_a), .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd),
    .o_dbg_state(dbg_state)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .ext_grant_cnt(ext_grant_cnt)
`endif
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write at the rising edge.
  assign ram_rd = mem[ram_a[9:2]];
  always @(posedge clk) if (ram_we) mem[ram_a[9:2]] <= ram_wd;

  // Driver: push the expected outputs for the current cycle, then advance.
  task automatic step(input logic e_st, input logic e_stall, input logic e_gnt,
                      input logic e_we, input logic e_rv, input logic e_chk,
                      input logic [31:0] e_rd);
    if (!rst_n) begin
      exp_conf = 16'd0;
      exp_gcnt = 16'd0;
    end
    exp_q.push_back({e_st, e_stall, e_gnt, e_we, e_rv, e_chk, exp_rdata, e_rd,
                     exp_conf, exp_gcnt});
    if (rst_n) begin
      exp_conf = exp_conf + {15'd0, e_stall};
      exp_gcnt = exp_gcnt + {15'd0, e_gnt};
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: compare once per cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EW-1:0] r;
      logic bad;
      r   = exp_q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (dbg_state !== r[101]) begin bad = 1'b1; $display("FAIL state t=%0t got %b exp %b", $time, dbg_state, r[101]); end
      if (stall_M !== r[100]) begin bad = 1'b1; $display("FAIL stall_M t=%0t got %b exp %b", $time, stall_M, r[100]); end
      if (ext_gnt !== r[99]) begin bad = 1'b1; $display("FAIL ext_gnt t=%0t got %b exp %b", $time, ext_gnt, r[99]); end
      if (ram_we !== r[98]) begin bad = 1'b1; $display("FAIL ram_we t=%0t got %b exp %b", $time, ram_we, r[98]); end
      if (ext_rvalid !== r[97]) begin bad = 1'b1; $display("FAIL ext_rvalid t=%0t got %b exp %b", $time, ext_rvalid, r[97]); end
      if (ext_rdata !== r[95:64]) begin bad = 1'b1; $display("FAIL ext_rdata t=%0t got %h exp %h", $time, ext_rdata, r[95:64]); end
      if (r[96] && (read_data_M !== r[63:32])) begin
        bad = 1'b1; $display("FAIL read_data_M t=%0t got %h exp %h", $time, read_data_M, r[63:32]);
      end
`ifdef DMEM_ARB_STATS_EN
      if (conflict_cnt !== r[31:16]) begin bad = 1'b1; $display("FAIL conflict_cnt t=%0t got %0d exp %0d", $time, conflict_cnt, r[31:16]); end
      if (ext_grant_cnt !== r[15:0]) begin bad = 1'b1; $display("FAIL ext_grant_cnt t=%0t got %0d exp %0d", $time, ext_grant_cnt, r[15:0]); end
`endif
      if (bad) n_err++;
    end
  end

  // Directed scenarios.
  initial begin
    n_vec = 0; n_err = 0;
    exp_rdata = 32'd0; exp_conf = 16'd0; exp_gcnt = 16'd0;
    memRead_M = 0; memWrite_M = 0; ALU_out_M = 0; writeData_M = 0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 0; ext_wdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    rst_n = 1'b1;
    step(0,0,0,0,0,0,0);

    // CPU-only write then read, zero-latency read data.
    memWrite_M = 1; ALU_out_M = 32'h10; writeData_M = 32'hA5A5_0001;
    step(0,0,0,1,0,0,0);
    memWrite_M = 0; memRead_M = 1;
    step(0,0,0,0,0,1,32'hA5A5_0001);

    // EXT-only read, data one cycle later.
    memRead_M = 0; ext_req = 1; ext_we = 0; ext_addr = 32'h10;
    step(0,0,1,0,0,0,0);
    ext_req = 0; exp_rdata = 32'hA5A5_0001;
    step(0,0,0,0,1,0,0);

    // EXT-only write, then CPU reads it back.
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h1234_5678;
    step(0,0,1,1,0,0,0);
    ext_req = 0; ext_we = 0; memRead_M = 1; ALU_out_M = 32'h20;
    step(0,0,0,0,0,1,32'h1234_5678);

    // Contention: 4 refusals, forced grant on the 5th, CPU back next cycle.
    ALU_out_M = 32'h10; ext_req = 1; ext_addr = 32'h20;
    repeat (4) step(0,0,0,0,0,1,32'hA5A5_0001);
    step(0,1,1,0,0,0,0);
    ext_req = 0; exp_rdata = 32'h1234_5678;
    step(0,0,0,0,1,1,32'hA5A5_0001);

    // Same-address writes: only the owner writes, data never merged.
    memRead_M = 0; memWrite_M = 1; ALU_out_M = 32'h30; writeData_M = 32'h1111_1111;
    ext_req = 1; ext_we = 1; ext_addr = 32'h30; ext_wdata = 32'h2222_2222;
    repeat (4) step(0,0,0,1,0,0,0);
    step(0,1,1,1,0,0,0);
    memWrite_M = 0; memRead_M = 1; ext_req = 0; ext_we = 0;
    step(0,0,0,0,0,1,32'h2222_2222);

    // Locked burst: 8 grants, forced release, CPU granted, EXT resumes.
    ALU_out_M = 32'h10; ext_req = 1; ext_lock = 1; ext_addr = 32'h20;
    repeat (4) step(0,0,0,0,0,1,32'hA5A5_0001);
    step(0,1,1,0,0,0,0);
    repeat (7) step(1,1,1,0,1,0,0);
    step(0,0,0,0,1,1,32'hA5A5_0001);
    repeat (3) step(0,0,0,0,0,1,32'hA5A5_0001);
    step(0,1,1,0,0,0,0);
    ext_lock = 0;
    step(1,1,1,0,1,0,0);
    ext_req = 0;
    step(0,0,0,0,1,1,32'hA5A5_0001);
    memRead_M = 0;
    step(0,0,0,0,0,0,0);

    // Reset asserted mid-burst: everything drops at once, no stall afterwards.
    memWrite_M = 1; ALU_out_M = 32'h40; writeData_M = 32'h5555_5555;
    ext_req = 1; ext_lock = 1; ext_addr = 32'h20;
    repeat (4) step(0,0,0,1,0,0,0);
    step(0,1,1,0,0,0,0);
    step(1,1,1,0,1,0,0);
    rst_n = 1'b0; exp_rdata = 32'd0;
    step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    rst_n = 1'b1; ext_lock = 0;
    step(0,0,0,1,0,0,0);
    memWrite_M = 0; ext_req = 0;
    step(0,0,0,0,0,0,0);

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
